fighter_ctrl: RTL and testbench
===============================

Name: fighter_ctrl

Overview:
Per-player fighter controller, parametrised successor to the existing stick-figure movement block. It decodes up to NKEYS USB keycodes and runs an action state machine with timed attacks, cooldown, hit reaction (stagger/knockback) and a ballistic jump. It resolves arena-edge and opponent-contact collisions, and emits position, state and outgoing hit to the renderer and to the opposing fighter_ctrl instance. Two instances sit in the top level, cross-coupled through opp_* and hit_* ports.

Parameters:
NKEYS, 4, number of 8-bit keycode slots scanned
X_INIT, 0 / Y_INIT, 300, spawn position; Y_INIT is also ground level
X_MIN, 0 / X_MAX, 639, arena horizontal bounds
FIGHTER_W, 80, sprite width used for right-edge clamp
STEP, 5 / BACK_STEP, 1 / KNOCK_STEP, 8, per-tick horizontal speeds
NEAR_X, 40 / NEAR_Y, 50, contact distances
ATTACK_FRAMES, 8 / COOLDOWN_FRAMES, 4 / DODGE_FRAMES, 6 / STAGGER_FRAMES, 6 / KNOCK_FRAMES, 5, state durations in ticks
JUMP_V, 12, initial upward speed; gravity fixed at 1/tick
KEY_LEFT 8'h04, KEY_RIGHT 8'h07, KEY_KICK 8'h18, KEY_PUNCH 8'h0C, KEY_DODGE 8'h1C, KEY_JUMP 8'h1A, KEY_START 8'h28, key bindings

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high
frame_tick  in  1  one-Clk pulse per video frame; all state advances only on it
keys  in  NKEYS*8  packed keycodes, slot 0 in [7:0]
opp_x, opp_y  in  10  opponent position
opp_busy  in  1  opponent in KICK/PUNCH/DODGE/JUMP
hit_in  in  2  0 none, 1 light, 2 heavy (sampled on frame_tick)
game_over  in  1  round finished
pos_x, pos_y  out  10  fighter position
state  out  4  fighter_pkg::fstate_t
hit_out  out  2  outgoing hit, valid for exactly one tick
near  out  1  near_x AND near_y (combinational)
start  out  1  sticky start request

Behaviour:
- Reset (async): pos=(X_INIT,Y_INIT), state=IDLE, timer=0, vy=0, hit_out=0, start=0.
- Between ticks all registers hold. Every update happens in the Clk cycle in which frame_tick=1. Position and state update in the same tick (no extra frame of motion latency).
- Key match: a key is pressed if any slot equals its code. Start priority: kick > punch > dodge > jump > left > right > none.
- Per-tick priority:
  1. game_over: state=IDLE, motion 0.
  2. hit_in=2 and state not DODGE/JUMP: enter KNOCKBACK, timer=KNOCK_FRAMES.
  3. hit_in=1 and state not DODGE/JUMP: enter STAGGER, timer=STAGGER_FRAMES.
  4. Timed state active: decrement timer; on expiry KICK/PUNCH -> COOLDOWN (COOLDOWN_FRAMES), others -> IDLE.
  5. Otherwise, from IDLE/WALK_*: decode keys. Attack/dodge/jump are blocked while opp_busy=1; walking is always allowed.
- States: IDLE, WALK_L, WALK_R, KICK, PUNCH, DODGE, JUMP, STAGGER, KNOCKBACK, COOLDOWN. WALK_* re-evaluates every tick; releasing the key returns to IDLE.
- hit_out: pulses on the tick where the KICK/PUNCH timer equals ATTACK_FRAMES/2, only if near=1. Value is 2 for kick, 1 for punch; otherwise 0.
- Horizontal motion, signed 11-bit: WALK ±STEP; JUMP ±STEP steered by left/right keys; KNOCKBACK KNOCK_STEP away from the opponent; all other states 0.
- Contact override (near_y and opponent ahead within NEAR_X in the motion direction): motion becomes BACK_STEP away from the opponent.
- Clamp: next x is saturated to [X_MIN, X_MAX-FIGHTER_W]; no wrap-around.
- Jump: on entry vy=-JUMP_V. Each tick y+=vy, then vy+=1. If y+vy >= Y_INIT: y=Y_INIT, vy=0, state=IDLE.
- Simultaneous hit and timer expiry: the hit wins.
- A hit during STAGGER or KNOCKBACK restarts the timer.
- start is set on a KEY_START press when game_over=0 and cleared only by Reset.

Decomposition:
- fighter_pkg: fstate_t enum, hit codes (HIT_NONE/LIGHT/HEAVY), default key constants.
- Sub-module fighter_jump_phys: holds y/vy, with inputs launch and frame_tick, outputs y and landed.

Test Plan:
- Reset, no keys, 10 ticks -> pos=(0,300), state=IDLE, hit_out=0.
- KEY_RIGHT in slot 2 for 4 ticks -> pos_x 5,10,15,20; state=WALK_R. Hold until clamp -> pos_x saturates at 559.
- KEY_JUMP with JUMP_V=12 -> y=222 on ticks 12-13, y=300 and state=IDLE on tick 25; hit_in=2 mid-jump is ignored.
- KEY_KICK, opponent 30 px right, same y -> hit_out=2 for one tick at timer=4; then COOLDOWN for 4 ticks, then IDLE; key ignored while opp_busy=1.
- hit_in=2 with opponent to the right at x=100 -> KNOCKBACK, pos_x decreases by 8/tick for 5 ticks, clamped at 0.
- Async Reset asserted mid-KNOCKBACK between ticks -> outputs at reset values immediately. KEY_START -> start=1 and stays 1 through game_over.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared types and constants for the fighter controller: action states,
// hit codes and default key bindings.
package fighter_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WALK_L,
    WALK_R,
    KICK,
    PUNCH,
    DODGE,
    JUMP,
    STAGGER,
    KNOCKBACK,
    COOLDOWN
  } fstate_t;

  localparam logic [1:0] HIT_NONE  = 2'd0;
  localparam logic [1:0] HIT_LIGHT = 2'd1;
  localparam logic [1:0] HIT_HEAVY = 2'd2;

  localparam logic [7:0] KEY_LEFT_DFLT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT_DFLT = 8'h07;
  localparam logic [7:0] KEY_KICK_DFLT  = 8'h18;
  localparam logic [7:0] KEY_PUNCH_DFLT = 8'h0C;
  localparam logic [7:0] KEY_DODGE_DFLT = 8'h1C;
  localparam logic [7:0] KEY_JUMP_DFLT  = 8'h1A;
  localparam logic [7:0] KEY_START_DFLT = 8'h28;

endpackage

// File: rtl/fighter_jump_phys.sv
// Ballistic vertical motion: launch sets an upward speed, gravity adds 1 per
// frame, and the fighter snaps back to ground level when the next step would reach it.
module fighter_jump_phys
  import fighter_pkg::*;
#(
  parameter int Y_INIT = 300,
  parameter int JUMP_V = 12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       launch,
  output logic [9:0] y,
  output logic       landed
);

  localparam logic signed [11:0] GROUND   = 12'(Y_INIT);
  localparam logic signed [11:0] V_LAUNCH = 12'(-JUMP_V);

  logic [9:0]         y_r;
  logic signed [11:0] vy_r;
  logic signed [11:0] y_next;
  logic               air_r;

  assign y_next = $signed({2'b00, y_r}) + vy_r;
  assign landed = air_r && (y_next >= GROUND);
  assign y      = y_r;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      y_r   <= 10'(Y_INIT);
      vy_r  <= '0;
      air_r <= 1'b0;
    end else if (frame_tick) begin
      if (launch) begin
        vy_r  <= V_LAUNCH;
        air_r <= 1'b1;
      end else if (air_r) begin
        if (landed) begin
          y_r   <= 10'(Y_INIT);
          vy_r  <= '0;
          air_r <= 1'b0;
        end else begin
          y_r  <= y_next[9:0];
          vy_r <= vy_r + 12'sd1;
        end
      end
    end
  end

endmodule

// File: rtl/fighter_ctrl.sv
// Per-player fighter controller: key decode, timed action FSM, hit exchange
// with the opponent, and horizontal motion with contact and arena clamping.
module fighter_ctrl
  import fighter_pkg::*;
#(
  parameter int NKEYS           = 4,
  parameter int X_INIT          = 0,
  parameter int Y_INIT          = 300,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int FIGHTER_W       = 80,
  parameter int STEP            = 5,
  parameter int BACK_STEP       = 1,
  parameter int KNOCK_STEP      = 8,
  parameter int NEAR_X          = 40,
  parameter int NEAR_Y          = 50,
  parameter int ATTACK_FRAMES   = 8,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int DODGE_FRAMES    = 6,
  parameter int STAGGER_FRAMES  = 6,
  parameter int KNOCK_FRAMES    = 5,
  parameter int JUMP_V          = 12,
  parameter logic [7:0] KEY_LEFT  = KEY_LEFT_DFLT,
  parameter logic [7:0] KEY_RIGHT = KEY_RIGHT_DFLT,
  parameter logic [7:0] KEY_KICK  = KEY_KICK_DFLT,
  parameter logic [7:0] KEY_PUNCH = KEY_PUNCH_DFLT,
  parameter logic [7:0] KEY_DODGE = KEY_DODGE_DFLT,
  parameter logic [7:0] KEY_JUMP  = KEY_JUMP_DFLT,
  parameter logic [7:0] KEY_START = KEY_START_DFLT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic [NKEYS*8-1:0] keys,
  input  logic [9:0]         opp_x,
  input  logic [9:0]         opp_y,
  input  logic               opp_busy,
  input  logic [1:0]         hit_in,
  input  logic               game_over,
  output logic [9:0]         pos_x,
  output logic [9:0]         pos_y,
  output fstate_t            state,
  output logic [1:0]         hit_out,
  output logic               near,
  output logic               start
);

  localparam logic signed [11:0] XLO     = 12'(X_MIN);
  localparam logic signed [11:0] XHI     = 12'(X_MAX - FIGHTER_W);
  localparam logic signed [11:0] STEP_S  = 12'(STEP);
  localparam logic signed [11:0] BACK_S  = 12'(BACK_STEP);
  localparam logic signed [11:0] KNOCK_S = 12'(KNOCK_STEP);
  localparam logic signed [11:0] NX_S    = 12'(NEAR_X);
  localparam logic signed [11:0] NY_S    = 12'(NEAR_Y);
  localparam logic [7:0] T_ATK   = 8'(ATTACK_FRAMES);
  localparam logic [7:0] T_HALF  = 8'(ATTACK_FRAMES / 2);
  localparam logic [7:0] T_COOL  = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] T_DODGE = 8'(DODGE_FRAMES);
  localparam logic [7:0] T_STAG  = 8'(STAGGER_FRAMES);
  localparam logic [7:0] T_KNOCK = 8'(KNOCK_FRAMES);

  function automatic logic key_hit(input logic [NKEYS*8-1:0] k, input logic [7:0] code);
    logic m;
    m = 1'b0;
    for (int i = 0; i < NKEYS; i++)
      if (k[i*8 +: 8] == code) m = 1'b1;
    return m;
  endfunction

  function automatic logic [9:0] sat_x(input logic signed [11:0] v);
    if (v < XLO) return XLO[9:0];
    if (v > XHI) return XHI[9:0];
    return v[9:0];
  endfunction

  fstate_t            state_r, nstate;
  logic [7:0]         timer_r, ntimer;
  logic [9:0]         x_r, nx, y_cur;
  logic [1:0]         hit_r, nhit;
  logic               start_r, launch, landed;
  logic               k_left, k_right, k_kick, k_punch, k_dodge, k_jump, k_start;
  logic signed [11:0] dx, dy, mot;
  logic               near_x, near_y, timed, evasive, is_attack;

  assign k_left  = key_hit(keys, KEY_LEFT);
  assign k_right = key_hit(keys, KEY_RIGHT);
  assign k_kick  = key_hit(keys, KEY_KICK);
  assign k_punch = key_hit(keys, KEY_PUNCH);
  assign k_dodge = key_hit(keys, KEY_DODGE);
  assign k_jump  = key_hit(keys, KEY_JUMP);
  assign k_start = key_hit(keys, KEY_START);

  assign dx     = $signed({2'b00, opp_x}) - $signed({2'b00, x_r});
  assign dy     = $signed({2'b00, opp_y}) - $signed({2'b00, y_cur});
  assign near_x = (dx < NX_S) && (dx > -NX_S);
  assign near_y = (dy < NY_S) && (dy > -NY_S);
  assign near   = near_x & near_y;

  assign timed     = state_r inside {KICK, PUNCH, DODGE, STAGGER, KNOCKBACK, COOLDOWN};
  assign evasive   = (state_r == DODGE) || (state_r == JUMP);
  assign is_attack = (state_r == KICK) || (state_r == PUNCH);

  fighter_jump_phys #(
    .Y_INIT(Y_INIT),
    .JUMP_V(JUMP_V)
  ) u_jump (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_tick(frame_tick),
    .launch    (launch),
    .y         (y_cur),
    .landed    (landed)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      timer_r <= '0;
      x_r     <= 10'(X_INIT);
      hit_r   <= HIT_NONE;
      start_r <= 1'b0;
    end else if (frame_tick) begin
      state_r <= nstate;
      timer_r <= ntimer;
      x_r     <= nx;
      hit_r   <= nhit;
      if (k_start && !game_over) start_r <= 1'b1;
    end
  end

  // Incoming hits pre-empt everything except dodge/jump, including a timer expiring this tick.
  always_comb begin
    nstate = state_r;
    ntimer = timer_r;
    nhit   = HIT_NONE;
    launch = 1'b0;
    if (game_over) begin
      nstate = IDLE;
      ntimer = '0;
    end else if (hit_in == HIT_HEAVY && !evasive) begin
      nstate = KNOCKBACK;
      ntimer = T_KNOCK;
    end else if (hit_in == HIT_LIGHT && !evasive) begin
      nstate = STAGGER;
      ntimer = T_STAG;
    end else if (timed) begin
      if (is_attack && timer_r == T_HALF && near)
        nhit = (state_r == KICK) ? HIT_HEAVY : HIT_LIGHT;
      if (timer_r <= 8'd1) begin
        if (is_attack) begin
          nstate = COOLDOWN;
          ntimer = T_COOL;
        end else begin
          nstate = IDLE;
          ntimer = '0;
        end
      end else begin
        ntimer = timer_r - 8'd1;
      end
    end else if (state_r == JUMP) begin
      if (landed) nstate = IDLE;
    end else begin
      ntimer = '0;
      if (!opp_busy && k_kick) begin
        nstate = KICK;
        ntimer = T_ATK;
      end else if (!opp_busy && k_punch) begin
        nstate = PUNCH;
        ntimer = T_ATK;
      end else if (!opp_busy && k_dodge) begin
        nstate = DODGE;
        ntimer = T_DODGE;
      end else if (!opp_busy && k_jump) begin
        nstate = JUMP;
        launch = 1'b1;
      end else if (k_left) begin
        nstate = WALK_L;
      end else if (k_right) begin
        nstate = WALK_R;
      end else begin
        nstate = IDLE;
      end
    end
  end

  // Motion follows the state being entered this tick so position never lags state.
  always_comb begin
    mot = '0;
    case (nstate)
      WALK_L:    mot = -STEP_S;
      WALK_R:    mot = STEP_S;
      JUMP: begin
        if (k_left)       mot = -STEP_S;
        else if (k_right) mot = STEP_S;
      end
      KNOCKBACK: mot = (dx >= 12'sd0) ? -KNOCK_S : KNOCK_S;
      default:   mot = '0;
    endcase
    if (near_y && mot > 12'sd0 && dx > 12'sd0 && dx < NX_S)
      mot = -BACK_S;
    else if (near_y && mot < 12'sd0 && dx < 12'sd0 && dx > -NX_S)
      mot = BACK_S;
  end

  assign nx = sat_x($signed({2'b00, x_r}) + mot);

  assign pos_x   = x_r;
  assign pos_y   = y_cur;
  assign state   = state_r;
  assign hit_out = hit_r;
  assign start   = start_r;

endmodule

// File: tb/tb_fighter_ctrl.sv
// Bench for fighter_ctrl: directed scenarios plus randomized frames checked
// against a rule-level model of the fighter.
module tb_fighter_ctrl;
  import fighter_pkg::*;

  localparam int NK = 4;

  logic            Clk = 1'b0;
  logic            Reset, frame_tick, opp_busy, game_over, near, start;
  logic [NK*8-1:0] keys;
  logic [9:0]      opp_x, opp_y, pos_x, pos_y;
  logic [1:0]      hit_in, hit_out;
  fstate_t         state;

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  int      mx, my, mvy, mtim, mhit;
  bit      mair, mstart;
  fstate_t mst;

  fighter_ctrl #(.NKEYS(NK)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_tick(frame_tick),
    .keys      (keys),
    .opp_x     (opp_x),
    .opp_y     (opp_y),
    .opp_busy  (opp_busy),
    .hit_in    (hit_in),
    .game_over (game_over),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .state     (state),
    .hit_out   (hit_out),
    .near      (near),
    .start     (start)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pressed(input logic [NK*8-1:0] k, input logic [7:0] code);
    for (int i = 0; i < NK; i++)
      if (k[i*8 +: 8] == code) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit m_near();
    return (iabs(int'(opp_x) - mx) < 40) && (iabs(int'(opp_y) - my) < 50);
  endfunction

  task automatic model_reset();
    mx = 0; my = 300; mvy = 0; mair = 1'b0;
    mst = IDLE; mtim = 0; mhit = 0; mstart = 1'b0;
  endtask

  // One frame of the fighter, straight from the behavioural rules.
  task automatic model_step();
    bit kl, kr, kk, kp, kd, kj, ks, ny, jump_go, atk, evade;
    int dx, mv, nx, nt, nh;
    fstate_t ns;
    kl = pressed(keys, KEY_LEFT_DFLT);  kr = pressed(keys, KEY_RIGHT_DFLT);
    kk = pressed(keys, KEY_KICK_DFLT);  kp = pressed(keys, KEY_PUNCH_DFLT);
    kd = pressed(keys, KEY_DODGE_DFLT); kj = pressed(keys, KEY_JUMP_DFLT);
    ks = pressed(keys, KEY_START_DFLT);
    dx = int'(opp_x) - mx;
    ny = iabs(int'(opp_y) - my) < 50;
    ns = mst; nt = mtim; nh = 0; jump_go = 1'b0;
    atk   = (mst == KICK) || (mst == PUNCH);
    evade = (mst == DODGE) || (mst == JUMP);
    if (game_over) begin
      ns = IDLE; nt = 0;
    end else if (hit_in == 2'd2 && !evade) begin
      ns = KNOCKBACK; nt = 5;
    end else if (hit_in == 2'd1 && !evade) begin
      ns = STAGGER; nt = 6;
    end else if (mst inside {KICK, PUNCH, DODGE, STAGGER, KNOCKBACK, COOLDOWN}) begin
      if (atk && mtim == 4 && iabs(dx) < 40 && ny) nh = (mst == KICK) ? 2 : 1;
      nt = mtim - 1;
      if (nt <= 0) begin
        if (atk) begin ns = COOLDOWN; nt = 4; end
        else begin ns = IDLE; nt = 0; end
      end
    end else if (mst == JUMP) begin
      if (mair && my + mvy >= 300) ns = IDLE;
    end else begin
      nt = 0;
      if (!opp_busy && kk)      begin ns = KICK;  nt = 8; end
      else if (!opp_busy && kp) begin ns = PUNCH; nt = 8; end
      else if (!opp_busy && kd) begin ns = DODGE; nt = 6; end
      else if (!opp_busy && kj) begin ns = JUMP;  jump_go = 1'b1; end
      else if (kl) ns = WALK_L;
      else if (kr) ns = WALK_R;
      else ns = IDLE;
    end
    mv = 0;
    if (ns == WALK_L) mv = -5;
    else if (ns == WALK_R) mv = 5;
    else if (ns == JUMP) mv = kl ? -5 : (kr ? 5 : 0);
    else if (ns == KNOCKBACK) mv = (dx >= 0) ? -8 : 8;
    if (ny && mv > 0 && dx > 0 && dx < 40) mv = -1;
    else if (ny && mv < 0 && dx < 0 && dx > -40) mv = 1;
    nx = mx + mv;
    if (nx < 0) nx = 0;
    if (nx > 559) nx = 559;
    if (!game_over && ks) mstart = 1'b1;
    if (jump_go) begin
      mvy = -12; mair = 1'b1;
    end else if (mair) begin
      if (my + mvy >= 300) begin my = 300; mvy = 0; mair = 1'b0; end
      else begin my = my + mvy; mvy = mvy + 1; end
    end
    mx = nx; mst = ns; mtim = nt; mhit = nh;
  endtask

  task automatic check_all();
    check_val("pos_x", pos_x, mx);
    check_val("pos_y", pos_y, my);
    check_val("state", state, mst);
    check_val("hit_out", hit_out, mhit);
    check_val("near", near, m_near());
    check_val("start", start, mstart);
  endtask

  task automatic tick();
    @(negedge Clk); frame_tick = 1'b1;
    @(posedge Clk); #1; frame_tick = 1'b0;
    model_step();
    check_all();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Reset = 1'b0;
    model_reset();
  endtask

  task automatic async_reset_now();
    @(negedge Clk); #2; Reset = 1'b1;
    #1; model_reset();
    check_all();
    @(negedge Clk); Reset = 1'b0;
  endtask

  task automatic rand_inputs();
    logic [7:0] codes [8];
    int r, v;
    codes = '{8'h04, 8'h07, 8'h18, 8'h0C, 8'h1C, 8'h1A, 8'h28, 8'h05};
    for (int s = 0; s < NK; s++) begin
      r = $urandom_range(0, 15);
      if (r < 7) keys[s*8 +: 8] = 8'h00;
      else if (r < 15) keys[s*8 +: 8] = codes[r-7];
      else keys[s*8 +: 8] = 8'($urandom_range(0, 255));
    end
    if ($urandom_range(0, 3) != 0) v = mx + int'($urandom_range(0, 120)) - 60;
    else v = int'($urandom_range(0, 639));
    if (v < 0) v = 0;
    if (v > 639) v = 639;
    opp_x = 10'(v);
    if ($urandom_range(0, 3) != 0) opp_y = 10'(240 + $urandom_range(0, 60));
    else opp_y = 10'($urandom_range(100, 400));
    opp_busy  = ($urandom_range(0, 3) == 0);
    r = $urandom_range(0, 31);
    hit_in    = (r == 0) ? 2'd2 : ((r == 1) ? 2'd1 : 2'd0);
    game_over = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; keys = '0; opp_x = 10'd600; opp_y = 10'd0;
    opp_busy = 1'b0; hit_in = 2'd0; game_over = 1'b0;
    model_reset();
    do_reset();
    #1; check_all();
    for (int k = 0; k < 10; k++) tick();
    check_val("idle_x", pos_x, 0);
    check_val("idle_y", pos_y, 300);
    check_val("idle_st", state, IDLE);

    // walk right with the key in slot 2, then hold into the right edge
    keys = 32'h0007_0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("walk_x", pos_x, 5 * (k + 1));
      check_val("walk_st", state, WALK_R);
    end
    for (int k = 0; k < 115; k++) tick();
    check_val("clamp_x", pos_x, 559);

    // jump; a heavy hit mid-air is ignored
    keys = '0; tick();
    keys = 32'h0000_001A; tick();
    check_val("jump_st", state, JUMP);
    keys = '0;
    for (int k = 1; k <= 25; k++) begin
      hit_in = (k == 6) ? 2'd2 : 2'd0;
      tick();
      if (k == 12 || k == 13) check_val("jump_apex", pos_y, 222);
      if (k == 6) check_val("jump_hit", state, JUMP);
    end
    check_val("land_y", pos_y, 300);
    check_val("land_st", state, IDLE);

    // kick with opponent 30 px to the right; blocked first by opp_busy
    do_reset();
    opp_x = 10'd30; opp_y = 10'd300; opp_busy = 1'b1; keys = 32'h0000_0018;
    tick();
    check_val("busy_st", state, IDLE);
    opp_busy = 1'b0; tick();
    check_val("kick_st", state, KICK);
    keys = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_val("kick_hit", hit_out, (k == 5) ? 2 : 0);
      if (k >= 8 && k <= 11) check_val("cool_st", state, COOLDOWN);
    end
    check_val("kick_end", state, IDLE);

    // knockback away from opponent at x=100, into the left edge
    do_reset();
    opp_x = 10'd100; opp_y = 10'd300; keys = 32'h0000_0007;
    for (int k = 0; k < 4; k++) tick();
    keys = '0; hit_in = 2'd2; tick();
    hit_in = 2'd0;
    check_val("kb_x0", pos_x, 12);
    check_val("kb_st", state, KNOCKBACK);
    for (int k = 0; k < 4; k++) tick();
    check_val("kb_clamp", pos_x, 0);
    tick();
    check_val("kb_end", state, IDLE);
    keys = 32'h0000_0007;
    for (int k = 0; k < 8; k++) tick();
    keys = '0; hit_in = 2'd2; tick();
    hit_in = 2'd0; tick();
    check_val("kb_x2", pos_x, 24);
    async_reset_now();
    check_val("arst_x", pos_x, 0);
    check_val("arst_st", state, IDLE);

    // sticky start, unaffected by game_over
    keys = 32'h0000_2800; tick();
    check_val("start_set", start, 1);
    game_over = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    keys = '0; game_over = 1'b0; tick();
    check_val("start_hold", start, 1);

    // randomized frames with idle clocks in between
    do_reset();
    for (int it = 0; it < 2500; it++) begin
      rand_inputs();
      repeat ($urandom_range(0, 2)) @(posedge Clk);
      #1;
      check_val("hold_x", pos_x, mx);
      check_val("hold_st", state, mst);
      if ($urandom_range(0, 299) == 0) async_reset_now();
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
